tdm_demux4: RTL
===============

Name: tdm_demux4

Overview:
- Receive-end counterpart of the team's 4:1 select mux (mux4to1): recovers four channels from a time-division-multiplexed stream.
- The transmit side scans select codes 00, 01, 10, 11 and places one sample per slot on a shared line, marking slot 00 with a frame-sync strobe.
- This block tracks slot position, captures each slot into a shadow register, and publishes all four channels atomically once per frame.
- It detects sync loss and re-acquires sync.

Parameters:
- DATA_W, 1: width of one slot sample (i0..i3 width on the transmit side).
- MISS_MAX, 2: consecutive missing frame syncs tolerated in LOCK before dropping to HUNT (range 1..15).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- din  in  DATA_W  slot sample.
- din_valid  in  1  din is a valid slot this cycle; idle cycles do not advance the slot.
- fsync  in  1  qualified by din_valid; marks the current sample as slot 0.
- y0, y1, y2, y3  out  DATA_W each  registered recovered channels (slots 00, 01, 10, 11).
- frame_valid  out  1  one-cycle pulse when y0..y3 are updated.
- s1, s0  out  1 each  registered slot index of the next expected sample.
- locked  out  1  high in LOCK state.
- sync_err  out  1  one-cycle pulse on a sync error.

Behaviour:
- Reset (async assert, sync release):
  - State = HUNT; slot counter = 0; miss counter = 0.
  - y0..y3 = 0, frame_valid = 0, s1 = s0 = 0, locked = 0, sync_err = 0.
  - Shadow registers cleared.
- Cycles with din_valid=0 change nothing, apart from clearing the frame_valid and sync_err pulses; fsync is ignored on those cycles.
- HUNT:
  - Samples are discarded.
  - A valid sample with fsync=1 is captured as slot 0; slot counter becomes 1; state goes to LOCK; miss counter clears.
  - locked rises in the cycle after that sample.
- LOCK, valid sample, slot counter = k:
  - The sample is written to shadow[k].
  - The slot counter increments modulo 4, wrapping 3 -> 0.
- End of frame (k = 3):
  - In the cycle after the slot-3 sample, y0..y2 = shadow[0..2] and y3 = that slot-3 sample, all updated together; frame_valid = 1 for exactly one cycle.
  - Latency: one clock from the slot-3 sample to the output update.
- LOCK, k = 0, fsync = 0 (missing sync):
  - sync_err pulses and the miss counter increments.
  - The sample is still captured as slot 0 (flywheel).
  - If the incremented miss count equals MISS_MAX: go to HUNT, discard the sample, slot counter = 0, locked falls. y0..y3 hold their last values.
- LOCK, k = 0, fsync = 1: normal frame start; miss counter clears.
- LOCK, k ≠ 0, fsync = 1 (early sync):
  - sync_err pulses; the partial frame is discarded and no frame_valid is produced.
  - The sample is captured as slot 0; slot counter = 1; miss counter clears; state stays LOCK.
- Outputs y0..y3 change only on a frame_valid cycle or on reset.
- s1, s0 always reflect the slot counter: {s1, s0} = k.
- Reset mid-frame: asynchronous clear of everything, no frame_valid. After release, the block needs a fresh fsync to lock.

Test Plan:
- Reset then lock:
  - Stimulus: rst pulse; then valid samples 1, 0, 1, 0 (DATA_W=1) with fsync on the first.
  - Required: locked=1 after the first sample; the cycle after the 4th sample gives y0=1, y1=0, y2=1, y3=0 and a single frame_valid pulse; {s1, s0} steps 01, 10, 11, 00.
- Idle gaps:
  - Stimulus: same frame with din_valid=0 for 3 cycles between each sample.
  - Required: identical outputs; {s1, s0} frozen during the gaps; exactly one frame_valid.
- Early sync:
  - Stimulus: while LOCKed, fsync with the sample at slot 2.
  - Required: sync_err pulse; no frame_valid for the partial frame; the next 3 valid samples complete a frame that includes the resync sample as y0.
- Missing sync, MISS_MAX=2:
  - Stimulus: one frame without fsync.
  - Required: sync_err pulse, frame still output, locked stays 1.
  - Stimulus: second consecutive frame without fsync.
  - Required: sync_err pulse, locked=0, y0..y3 unchanged, no frame_valid.
- Async reset mid-frame:
  - Stimulus: assert rst between the slot-1 and slot-2 samples.
  - Required: immediate y0..y3 = 0, locked = 0, {s1, s0} = 00; samples after release without fsync are ignored.
- DATA_W=8 with back-to-back frames:
  - Stimulus: valid every cycle, values 0xA5, 0x3C, 0xFF, 0x00, then a second frame 0x01, 0x02, 0x03, 0x04.
  - Required: frame_valid every 4 cycles; outputs A5/3C/FF/00, then 01/02/03/04.

Source files
------------

// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - four-slot TDM receive demultiplexer with frame-sync tracking
// Captures slots into shadow registers and publishes all four channels once per frame.
module tdm_demux4 #(
    parameter int DATA_W   = 1,
    parameter int MISS_MAX = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              fsync,
    output logic [DATA_W-1:0] y0,
    output logic [DATA_W-1:0] y1,
    output logic [DATA_W-1:0] y2,
    output logic [DATA_W-1:0] y3,
    output logic              frame_valid,
    output logic              s1,
    output logic              s0,
    output logic              locked,
    output logic              sync_err
);

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    localparam logic [3:0] LP_MISS_MAX = 4'(MISS_MAX);

    state_t            r_state;
    logic [1:0]        r_slot;
    logic [3:0]        r_miss;
    logic [DATA_W-1:0] r_sh0;
    logic [DATA_W-1:0] r_sh1;
    logic [DATA_W-1:0] r_sh2;
    logic [DATA_W-1:0] r_y0;
    logic [DATA_W-1:0] r_y1;
    logic [DATA_W-1:0] r_y2;
    logic [DATA_W-1:0] r_y3;
    logic              r_frame_valid;
    logic              r_locked;
    logic              r_sync_err;

    logic [3:0]        w_miss_inc;
    logic              w_miss_trip;

    assign w_miss_inc  = r_miss + 4'd1;
    assign w_miss_trip = (w_miss_inc == LP_MISS_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_HUNT;
            r_slot        <= 2'd0;
            r_miss        <= 4'd0;
            r_sh0         <= '0;
            r_sh1         <= '0;
            r_sh2         <= '0;
            r_y0          <= '0;
            r_y1          <= '0;
            r_y2          <= '0;
            r_y3          <= '0;
            r_frame_valid <= 1'b0;
            r_locked      <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            if (din_valid) begin
                if (r_state == ST_HUNT) begin
                    if (fsync) begin
                        r_sh0    <= din;
                        r_slot   <= 2'd1;
                        r_miss   <= 4'd0;
                        r_state  <= ST_LOCK;
                        r_locked <= 1'b1;
                    end
                end else if (r_slot == 2'd0) begin
                    if (fsync) begin
                        r_sh0  <= din;
                        r_slot <= 2'd1;
                        r_miss <= 4'd0;
                    end else begin
                        // Missing sync: flywheel on until the miss budget runs out.
                        r_sync_err <= 1'b1;
                        if (w_miss_trip) begin
                            r_state  <= ST_HUNT;
                            r_locked <= 1'b0;
                            r_slot   <= 2'd0;
                            r_miss   <= 4'd0;
                        end else begin
                            r_miss <= w_miss_inc;
                            r_sh0  <= din;
                            r_slot <= 2'd1;
                        end
                    end
                end else if (fsync) begin
                    // Early sync restarts the frame; the partial frame is dropped.
                    r_sync_err <= 1'b1;
                    r_sh0      <= din;
                    r_slot     <= 2'd1;
                    r_miss     <= 4'd0;
                end else begin
                    case (r_slot)
                        2'd1: r_sh1 <= din;
                        2'd2: r_sh2 <= din;
                        default: begin
                            r_y0          <= r_sh0;
                            r_y1          <= r_sh1;
                            r_y2          <= r_sh2;
                            r_y3          <= din;
                            r_frame_valid <= 1'b1;
                        end
                    endcase
                    r_slot <= r_slot + 2'd1;
                end
            end
        end
    end

    assign y0          = r_y0;
    assign y1          = r_y1;
    assign y2          = r_y2;
    assign y3          = r_y3;
    assign frame_valid = r_frame_valid;
    assign s1          = r_slot[1];
    assign s0          = r_slot[0];
    assign locked      = r_locked;
    assign sync_err    = r_sync_err;

endmodule
